ysyx_22051013_mem_arb: RTL and testbench

- Two-requester arbiter sharing the single 64-bit data-memory port between instruction fetch (IF) and load/store unit (LS).
- One outstanding transaction at a time; requests and responses are latched; address forced 8-byte aligned.
- Round-robin on simultaneous requests; per-transaction timeout returns an error response so the core never hangs.
- Sits between IFU/LSU and the DPI memory wrapper.

---
 rtl/ysyx_22051013_mem_arb_pkg.sv | 23 ++
 rtl/ysyx_22051013_rr_arb2.sv | 21 ++
 rtl/ysyx_22051013_mem_arb.sv | 152 +++++++++++++++
 tb/tb_ysyx_22051013_mem_arb.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22051013_mem_arb_pkg.sv
// Shared encodings for the IF/LS data-memory arbiter: FSM states, grant owners,
// and the constants used to zero data and force 8-byte address alignment.
package ysyx_22051013_mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    // Owner encoding, also used for the round-robin history bit.
    localparam logic GRANT_IF = 1'b0;
    localparam logic GRANT_LS = 1'b1;

    // Bit positions inside the 2-bit request/grant vectors.
    localparam int GNT_IF_BIT = 0;
    localparam int GNT_LS_BIT = 1;

    localparam logic [63:0] ZERO64          = 64'h0;
    localparam logic [63:0] ADDR_ALIGN_MASK = 64'hFFFF_FFFF_FFFF_FFF8;

endpackage

// File: rtl/ysyx_22051013_rr_arb2.sv
// Two-way round-robin picker: a lone request wins outright, a tie goes to the
// requester that did not win last time. Purely combinational, one-hot output.
module ysyx_22051013_rr_arb2
    import ysyx_22051013_mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (last == GRANT_IF) ? 2'b10 : 2'b01;
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/ysyx_22051013_mem_arb.sv
// Shares one 64-bit data-memory port between instruction fetch and the LSU,
// one transaction at a time, with a per-transaction timeout that forces an error.
module ysyx_22051013_mem_arb
    import ysyx_22051013_mem_arb_pkg::*;
#(
    parameter int ADDR_W  = 64,
    parameter int DATA_W  = 64,
    parameter int TIMEOUT = 256
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req_valid,
    output logic                if_req_ready,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_resp_valid,
    output logic [DATA_W-1:0]   if_rdata,
    output logic                if_resp_err,
    input  logic                ls_req_valid,
    output logic                ls_req_ready,
    input  logic                ls_we,
    input  logic [ADDR_W-1:0]   ls_addr,
    input  logic [DATA_W-1:0]   ls_wdata,
    input  logic [DATA_W/8-1:0] ls_wmask,
    output logic                ls_resp_valid,
    output logic [DATA_W-1:0]   ls_rdata,
    output logic                ls_resp_err,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wmask,
    input  logic                mem_resp_valid,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                busy
);

    localparam int          CNT_W  = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [31:0] TO_LIM = TIMEOUT;

    state_t              state;
    state_t              state_nxt;
    logic                last_grant;
    logic                owner_q;
    logic                we_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W/8-1:0] wmask_q;
    logic [DATA_W-1:0]   rdata_q;
    logic                err_q;
    logic [CNT_W-1:0]    cnt;

    logic [1:0]          gnt;
    logic                grant;
    logic                grant_ls;
    logic                in_flight;
    logic                timeout_hit;
    logic [ADDR_W-1:0]   sel_addr;

    ysyx_22051013_rr_arb2 u_pick (
        .req  ({ls_req_valid, if_req_valid}),
        .last (last_grant),
        .gnt  (gnt)
    );

    // Handshakes: a requester transfers in the cycle where valid && ready; ready
    // is combinational, only in IDLE, to one requester. Toward memory,
    // mem_req_valid and its fields stay stable until mem_req_ready is seen.
    assign if_req_ready = (state == ST_IDLE) && rst && gnt[GNT_IF_BIT];
    assign ls_req_ready = (state == ST_IDLE) && rst && gnt[GNT_LS_BIT];
    assign grant        = if_req_ready || ls_req_ready;
    assign grant_ls     = gnt[GNT_LS_BIT];
    assign sel_addr     = grant_ls ? ls_addr : if_addr;
    assign in_flight    = (state == ST_REQ) || (state == ST_WAIT);

    // Fires one cycle before the counter lands on TIMEOUT-1, so that value and
    // the forced RESP appear together, TIMEOUT cycles after the grant.
    assign timeout_hit = (TIMEOUT > 0) && ((32'(cnt) + 32'd2) >= TO_LIM);

    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_wmask = wmask_q;
    assign if_rdata  = rdata_q;
    assign ls_rdata  = rdata_q;
    assign if_resp_err = err_q;
    assign ls_resp_err = err_q;

    always_comb begin
        state_nxt     = state;
        mem_req_valid = 1'b0;
        if_resp_valid = 1'b0;
        ls_resp_valid = 1'b0;
        busy          = (state != ST_IDLE);
        case (state)
            ST_IDLE: begin
                if (grant) state_nxt = ST_REQ;
            end
            ST_REQ: begin
                mem_req_valid = 1'b1;
                if (timeout_hit)        state_nxt = ST_RESP;
                else if (mem_req_ready) state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (mem_resp_valid || timeout_hit) state_nxt = ST_RESP;
            end
            ST_RESP: begin
                if_resp_valid = (owner_q == GRANT_IF);
                ls_resp_valid = (owner_q == GRANT_LS);
                state_nxt     = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= ST_IDLE;
            last_grant <= GRANT_IF;
            owner_q    <= GRANT_IF;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wmask_q    <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
            cnt        <= '0;
        end else begin
            state <= state_nxt;
            if (grant) begin
                owner_q    <= grant_ls ? GRANT_LS : GRANT_IF;
                last_grant <= grant_ls ? GRANT_LS : GRANT_IF;
                we_q       <= grant_ls && ls_we;
                addr_q     <= sel_addr & ADDR_ALIGN_MASK[ADDR_W-1:0];
                wdata_q    <= grant_ls ? ls_wdata : ZERO64[DATA_W-1:0];
                wmask_q    <= (grant_ls && ls_we) ? ls_wmask : '0;
                cnt        <= '0;
            end else if (in_flight) begin
                cnt <= cnt + CNT_W'(1);
            end
            // A real response in WAIT beats a timeout landing in the same cycle.
            if ((state == ST_WAIT) && mem_resp_valid) begin
                rdata_q <= we_q ? ZERO64[DATA_W-1:0] : mem_rdata;
                err_q   <= 1'b0;
            end else if (in_flight && timeout_hit) begin
                rdata_q <= ZERO64[DATA_W-1:0];
                err_q   <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ysyx_22051013_mem_arb.sv
// Bench for ysyx_22051013_mem_arb: directed vector table, reset/late-response
// sequences, then random transactions checked against a transaction-level model.
module tb_ysyx_22051013_mem_arb;

    localparam int TO = 8;

    logic        clk;
    logic        rst;
    logic        if_req_valid;
    logic        if_req_ready;
    logic [63:0] if_addr;
    logic        if_resp_valid;
    logic [63:0] if_rdata;
    logic        if_resp_err;
    logic        ls_req_valid;
    logic        ls_req_ready;
    logic        ls_we;
    logic [63:0] ls_addr;
    logic [63:0] ls_wdata;
    logic [7:0]  ls_wmask;
    logic        ls_resp_valid;
    logic [63:0] ls_rdata;
    logic        ls_resp_err;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [7:0]  mem_wmask;
    logic        mem_resp_valid;
    logic [63:0] mem_rdata;
    logic        busy;

    int checks;
    int failures;

    typedef struct {
        bit          if_v;
        bit          ls_v;
        bit          we;
        logic [63:0] if_a;
        logic [63:0] ls_a;
        logic [63:0] wdata;
        logic [7:0]  wmask;
        logic [63:0] mem_data;
        int          d;      // REQ cycles with mem_req_ready low before accept
        int          r;      // cycles from accept to memory response
        bit          spur;   // extra mem_resp_valid in IDLE and on the accept cycle
        bit          exp_ls;
        logic [63:0] exp_addr;
        logic        exp_err;
        logic [63:0] exp_rdata;
        int          exp_lat;
    } vec_t;

    ysyx_22051013_mem_arb #(.ADDR_W(64), .DATA_W(64), .TIMEOUT(TO)) dut (
        .clk            (clk),
        .rst            (rst),
        .if_req_valid   (if_req_valid),
        .if_req_ready   (if_req_ready),
        .if_addr        (if_addr),
        .if_resp_valid  (if_resp_valid),
        .if_rdata       (if_rdata),
        .if_resp_err    (if_resp_err),
        .ls_req_valid   (ls_req_valid),
        .ls_req_ready   (ls_req_ready),
        .ls_we          (ls_we),
        .ls_addr        (ls_addr),
        .ls_wdata       (ls_wdata),
        .ls_wmask       (ls_wmask),
        .ls_resp_valid  (ls_resp_valid),
        .ls_rdata       (ls_rdata),
        .ls_resp_err    (ls_resp_err),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_wmask      (mem_wmask),
        .mem_resp_valid (mem_resp_valid),
        .mem_rdata      (mem_rdata),
        .busy           (busy)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_if_ready"},  64'(if_req_ready), 0);
        check({tag, "_ls_ready"},  64'(ls_req_ready), 0);
        check({tag, "_busy"},      64'(busy), 0);
        check({tag, "_mem_valid"}, 64'(mem_req_valid), 0);
        check({tag, "_mem_we"},    64'(mem_we), 0);
        check({tag, "_mem_addr"},  mem_addr, 0);
        check({tag, "_mem_wdata"}, mem_wdata, 0);
        check({tag, "_mem_wmask"}, 64'(mem_wmask), 0);
        check({tag, "_if_rv"},     64'(if_resp_valid), 0);
        check({tag, "_ls_rv"},     64'(ls_resp_valid), 0);
        check({tag, "_if_rdata"},  if_rdata, 0);
        check({tag, "_ls_rdata"},  ls_rdata, 0);
        check({tag, "_if_err"},    64'(if_resp_err), 0);
        check({tag, "_ls_err"},    64'(ls_resp_err), 0);
    endtask

    // Reference model: owner from the round-robin rule, latency and result from
    // when the response lands relative to the TIMEOUT window after the grant.
    function automatic vec_t model(input vec_t v, inout bit last_ls);
        vec_t m;
        int   done_at;
        m = v;
        m.exp_ls = (v.if_v && v.ls_v) ? !last_ls : v.ls_v;
        last_ls = m.exp_ls;
        m.exp_addr = m.exp_ls ? (v.ls_a - (v.ls_a % 8)) : (v.if_a - (v.if_a % 8));
        done_at = 2 + v.d + v.r;
        m.exp_err = (done_at > TO);
        m.exp_lat = m.exp_err ? TO : done_at;
        m.exp_rdata = (m.exp_err || (m.exp_ls && v.we)) ? 64'h0 : v.mem_data;
        return m;
    endfunction

    function automatic vec_t mk(bit if_v, bit ls_v, bit we, logic [63:0] if_a, logic [63:0] ls_a,
                                logic [63:0] wdata, logic [7:0] wmask, logic [63:0] mem_data,
                                int d, int r, bit spur, bit exp_ls, logic [63:0] exp_addr,
                                logic exp_err, logic [63:0] exp_rdata, int exp_lat);
        vec_t v;
        v.if_v = if_v; v.ls_v = ls_v; v.we = we; v.if_a = if_a; v.ls_a = ls_a;
        v.wdata = wdata; v.wmask = wmask; v.mem_data = mem_data; v.d = d; v.r = r;
        v.spur = spur; v.exp_ls = exp_ls; v.exp_addr = exp_addr; v.exp_err = exp_err;
        v.exp_rdata = exp_rdata; v.exp_lat = exp_lat;
        return v;
    endfunction

    // driver: one transaction from grant (c = 0) through its RESP cycle
    task automatic run_vec(input vec_t v);
        int   n_resp;
        int   seen_lat;
        bit   is_store;
        bit   req_exp;
        logic own_rv;
        logic oth_rv;
        n_resp   = 0;
        seen_lat = -1;
        is_store = v.exp_ls && v.we;
        for (int c = 0; c <= v.exp_lat; c++) begin
            @(negedge clk);
            if (c == 0) begin
                if_req_valid = v.if_v;
                ls_req_valid = v.ls_v;
                if_addr  = v.if_a;
                ls_addr  = v.ls_a;
                ls_we    = v.we;
                ls_wdata = v.wdata;
                ls_wmask = v.wmask;
            end else begin
                if_req_valid = v.if_v && v.exp_ls;
                ls_req_valid = v.ls_v && !v.exp_ls;
                if_addr  = {$urandom, $urandom};
                ls_addr  = {$urandom, $urandom};
                ls_we    = 1'($urandom);
                ls_wdata = {$urandom, $urandom};
                ls_wmask = 8'($urandom);
            end
            mem_req_ready  = (c == 1 + v.d);
            mem_resp_valid = (c == 1 + v.d + v.r) || (v.spur && (c == 0 || c == 1 + v.d));
            mem_rdata      = (c == 1 + v.d + v.r) ? v.mem_data : {$urandom, $urandom};
            #1;
            check("if_req_ready", 64'(if_req_ready), 64'(c == 0 && v.if_v && !v.exp_ls));
            check("ls_req_ready", 64'(ls_req_ready), 64'(c == 0 && v.ls_v && v.exp_ls));
            check("busy", 64'(busy), 64'(c != 0));
            req_exp = (c >= 1) && (c <= 1 + v.d) && (c < v.exp_lat);
            check("mem_req_valid", 64'(mem_req_valid), 64'(req_exp));
            if (req_exp) begin
                check("mem_addr", mem_addr, v.exp_addr);
                check("mem_we", 64'(mem_we), 64'(is_store));
                check("mem_wmask", 64'(mem_wmask), is_store ? 64'(v.wmask) : 64'h0);
                if (is_store) check("mem_wdata", mem_wdata, v.wdata);
            end
            own_rv = v.exp_ls ? ls_resp_valid : if_resp_valid;
            oth_rv = v.exp_ls ? if_resp_valid : ls_resp_valid;
            if (own_rv) begin
                n_resp++;
                seen_lat = c;
                check("resp_rdata", v.exp_ls ? ls_rdata : if_rdata, v.exp_rdata);
                check("resp_err", 64'(v.exp_ls ? ls_resp_err : if_resp_err), 64'(v.exp_err));
            end
            check("other_resp_valid", 64'(oth_rv), 0);
        end
        check("resp_count", 64'(n_resp), 1);
        check("resp_latency", 64'(seen_lat), 64'(v.exp_lat));
    endtask

    vec_t dir_tab[10];
    vec_t v;
    bit   model_last;
    int   kind;

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b0;
        if_req_valid = 0; ls_req_valid = 0; ls_we = 0;
        if_addr = 0; ls_addr = 0; ls_wdata = 0; ls_wmask = 0;
        mem_req_ready = 0; mem_resp_valid = 0; mem_rdata = 0;

        // directed table, applied straight out of reset (history = IF)
        dir_tab[0] = mk(1, 1, 0, 64'h8000_1000, 64'h8000_2008, 0, 0, 64'hA5A5_0000_0000_0001,
                        1, 1, 0, 1, 64'h8000_2008, 0, 64'hA5A5_0000_0000_0001, 4);
        dir_tab[1] = mk(1, 1, 0, 64'h8000_1000, 64'h8000_3000, 0, 0, 64'h0102_0304_0506_0708,
                        0, 1, 1, 0, 64'h8000_1000, 0, 64'h0102_0304_0506_0708, 3);
        dir_tab[2] = mk(1, 1, 1, 64'h8000_1008, 64'h8000_3000, 64'h1234_5678_0000_0000, 8'hF0,
                        64'hFFFF, 2, 1, 0, 1, 64'h8000_3000, 0, 64'h0, 5);
        dir_tab[3] = mk(1, 1, 0, 64'h8000_1008, 64'h8000_3000, 0, 0, 64'h5555,
                        0, 3, 0, 0, 64'h8000_1008, 0, 64'h5555, 5);
        dir_tab[4] = mk(1, 0, 0, 64'h8000_0004, 64'h0, 0, 0, 64'h1122_3344_5566_7788,
                        0, 2, 0, 0, 64'h8000_0000, 0, 64'h1122_3344_5566_7788, 4);
        dir_tab[5] = mk(0, 1, 1, 64'h0, 64'h8000_0013, 64'hAB00_0000, 8'h08, 64'hDEAD_BEEF,
                        3, 1, 0, 1, 64'h8000_0010, 0, 64'h0, 6);
        dir_tab[6] = mk(0, 1, 0, 64'h0, 64'h8000_0017, 0, 0, 64'hCAFE,
                        0, 1, 0, 1, 64'h8000_0010, 0, 64'hCAFE, 3);
        dir_tab[7] = mk(1, 1, 0, 64'h8000_0020, 64'h8000_0040, 0, 0, 64'h77,
                        1, 5, 0, 0, 64'h8000_0020, 0, 64'h77, 8);
        dir_tab[8] = mk(0, 1, 0, 64'h0, 64'h8000_0048, 0, 0, 64'h99,
                        1, 6, 0, 1, 64'h8000_0048, 1, 64'h0, 8);
        dir_tab[9] = mk(0, 1, 0, 64'h0, 64'h8000_0050, 0, 0, 64'h66,
                        20, 1, 0, 1, 64'h8000_0050, 1, 64'h0, 8);

        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b1;

        foreach (dir_tab[i]) run_vec(dir_tab[i]);

        // late responses after a timeout are ignored; held err/rdata stay put
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if_req_valid = 0; ls_req_valid = 0; mem_req_ready = 0;
            mem_resp_valid = (k == 1);
            mem_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
            #1;
            check("late_busy", 64'(busy), 0);
            check("late_mem_valid", 64'(mem_req_valid), 0);
            check("late_ls_rv", 64'(ls_resp_valid), 0);
            check("late_if_rv", 64'(if_resp_valid), 0);
            check("late_ls_rdata", ls_rdata, 0);
            check("late_ls_err", 64'(ls_resp_err), 1);
        end
        mem_resp_valid = 0;

        // reset while a load sits in WAIT
        @(negedge clk);
        ls_req_valid = 1; ls_we = 0; ls_addr = 64'h8000_0108; mem_req_ready = 1;
        #1;
        check("rw_grant", 64'(ls_req_ready), 1);
        @(negedge clk);
        ls_req_valid = 0;
        #1;
        check("rw_req", 64'(mem_req_valid), 1);
        @(negedge clk);
        mem_req_ready = 0;
        #1;
        check("rw_wait_busy", 64'(busy), 1);
        check("rw_wait_req", 64'(mem_req_valid), 0);
        @(negedge clk);
        rst = 1'b0; if_req_valid = 1; ls_req_valid = 1;
        @(negedge clk);
        #1;
        check_all_zero("rst_wait");
        @(negedge clk);
        rst = 1'b1; if_req_valid = 0; ls_req_valid = 0;
        mem_resp_valid = 1; mem_rdata = 64'h1357;
        #1;
        check("post_rst_ls_rv", 64'(ls_resp_valid), 0);
        check("post_rst_busy", 64'(busy), 0);
        @(negedge clk);
        mem_resp_valid = 0;
        #1;
        check("post_rst_ls_rv2", 64'(ls_resp_valid), 0);
        check("post_rst_if_rv2", 64'(if_resp_valid), 0);
        check("post_rst_rdata", ls_rdata, 0);
        run_vec(mk(1, 1, 0, 64'h8000_0200, 64'h8000_0300, 0, 0, 64'h2468,
                   0, 1, 0, 1, 64'h8000_0300, 0, 64'h2468, 3));
        model_last = 1'b1;

        // random transactions against the model
        for (int i = 0; i < 40; i++) begin
            kind = $urandom_range(0, 2);
            v.if_v = (kind != 1);
            v.ls_v = (kind != 0);
            v.we = 1'($urandom_range(0, 1));
            v.if_a = {$urandom, $urandom};
            v.ls_a = {$urandom, $urandom};
            v.wdata = {$urandom, $urandom};
            v.wmask = 8'($urandom);
            v.mem_data = {$urandom, $urandom};
            v.d = ($urandom_range(0, 4) == 0) ? $urandom_range(4, 9) : $urandom_range(0, 3);
            v.r = $urandom_range(1, 6);
            v.spur = 1'($urandom_range(0, 1));
            v = model(v, model_last);
            run_vec(v);
        end

        @(negedge clk);
        if_req_valid = 0; ls_req_valid = 0; mem_req_ready = 0; mem_resp_valid = 0;
        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
